// File: rtl/fifo_l2.sv
// fifo_l2: per-lane output buffer behind the L2 1:2 demux stage.
// Stores demuxed words, exposes occupancy and threshold flags, and pops
// on request. Overflow/underflow are sticky until reset.
// Build option: define FIFO_L2_FWFT_EN for first-word-fall-through reads;
// otherwise reads are registered with one cycle of latency.
module fifo_l2 #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] Entrada,
  input  logic                  validEntrada,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] Salida,
  output logic                  validSalida,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_CNT   = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0]   AE_CNT   = (ADDR_WIDTH+1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  overflow_reg;
  logic                  underflow_reg;
  logic                  pop_ok;
  logic                  push_ok;

  // Status flags are pure decodes of the registered occupancy.
  assign count        = count_reg;
  assign full         = (count_reg == FULL_CNT);
  assign empty        = (count_reg == '0);
  assign almost_full  = (count_reg >= AF_CNT);
  assign almost_empty = (count_reg <= AE_CNT);
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  // A pop needs stored data; a push into a full FIFO is only allowed when
  // the same cycle frees a slot. A word pushed into an empty FIFO is not
  // poppable until the following cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = validEntrada && (!full || pop_ok);

  // Occupancy moves only when exactly one side is accepted.
  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  // Storage array: write-only port here, contents are not reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= Entrada;
    end
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      if (validEntrada && !push_ok) begin
        overflow_reg <= 1'b1;
      end
      if (pop && !pop_ok) begin
        underflow_reg <= 1'b1;
      end
    end
  end

`ifdef FIFO_L2_FWFT_EN
  // Head of the queue is always presented; pop acknowledges it.
  assign Salida      = mem[rd_ptr_reg];
  assign validSalida = !empty;
`else
  logic [DATA_WIDTH-1:0] salida_reg;
  logic                  valid_reg;

  assign Salida      = salida_reg;
  assign validSalida = valid_reg;

  // Registered read port: popped word appears one cycle after the pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      salida_reg <= '0;
      valid_reg  <= 1'b0;
    end else begin
      valid_reg <= pop_ok;
      if (pop_ok) begin
        salida_reg <= mem[rd_ptr_reg];
      end
    end
  end
`endif

endmodule

// File: doc/fifo_l2.md
Name: fifo_l2

Overview:
- Per-lane output buffer placed directly downstream of the L2 1:2 demux stage.
- One instance consumes each demux output: Salida0/validSalida0 or Salida1/validSalida1.
- Stores demuxed bytes, exposes occupancy and threshold flags to the flow-control logic, and pops data on request toward the next stage.
- Overflow and underflow are reported through sticky error flags.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- DEPTH, 8, number of entries; must be a power of 2.
- ADDR_WIDTH, 3, log2(DEPTH); width of the read and write pointers.
- AF_THRESH, 6, count at or above which almost_full asserts.
- AE_THRESH, 2, count at or below which almost_empty asserts.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- Entrada  input  DATA_WIDTH  write data from the demux output.
- validEntrada  input  1  push request; data is written when accepted.
- pop  input  1  read request from the downstream stage.
- Salida  output  DATA_WIDTH  read data.
- validSalida  output  1  Salida holds a popped word.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- overflow  output  1  sticky: a push was rejected.
- underflow  output  1  sticky: a pop was rejected.

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr = rd_ptr = count = 0.
  - Salida = 0, validSalida = 0, overflow = underflow = 0.
  - Flags follow count, so after reset empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - Memory contents are don't-care.
- Release is sampled at the next rising edge.
- Reset asserted mid-operation discards all stored data and in-flight reads, and forces every output to its reset value within the same cycle.
- Status flags are combinational decodes of the registered count, so they reflect the result of a push or pop one cycle after the edge that performed it.
- Pointers are ADDR_WIDTH bits and wrap from DEPTH-1 to 0 with no gap. Occupancy is tracked by count, not by pointer comparison.

Push (validEntrada=1):
- Accepted if !full, or if full and a pop is accepted in the same cycle.
- On accept: mem[wr_ptr] <= Entrada, then wr_ptr advances.
- Rejected push (full and no accepted pop): data dropped, overflow <= 1; pointers and count unchanged.

Pop (pop=1):
- Accepted if !empty.
- On accept: Salida <= mem[rd_ptr], validSalida <= 1 in the next cycle, then rd_ptr advances. Read latency is 1 cycle.
- Cycles with no accepted pop: validSalida <= 0; Salida holds its last value.
- Rejected pop (empty): underflow <= 1; validSalida <= 0.
- A push into an empty FIFO is not poppable in the same cycle. The pop is rejected and flags underflow; the pushed word is still stored.

Count update:
- +1 on accepted push only.
- -1 on accepted pop only.
- Unchanged on both or neither.
- Saturation is impossible by construction.

Simultaneous push and pop:
- When full, both are accepted and count stays at DEPTH.
- When 0 < count < DEPTH, both are accepted and count is unchanged.

overflow and underflow are cleared only by reset.

Optional Feature:
- Macro: FIFO_L2_FWFT_EN.
- Defined (first-word-fall-through):
  - Salida = mem[rd_ptr] combinationally, validSalida = !empty.
  - pop acts as an acknowledge of the current head; the next word appears in the cycle after an accepted pop.
  - Salida is don't-care while empty.
  - Reset forces validSalida = 0.
- Not defined: the registered 1-cycle-latency read described in Behaviour.
- Push, count, flag and error rules are identical in both builds.

Test Plan:
- Reset, then push 0x11,0x22,0x33 on 3 consecutive cycles, then pop 3 cycles. Required: count reaches 3; Salida returns 0x11,0x22,0x33, each with validSalida=1 one cycle after its pop; count returns to 0 and empty=1.
- Push 8 words 0xA0..0xA7, then push 0xFF. Required: full=1 and almost_full=1 from count=6 onward; 0xFF dropped; overflow=1; draining returns 0xA0..0xA7 only.
- Pop while empty. Required: underflow=1, validSalida=0, count stays 0; underflow stays 1 until reset=0.
- Fill to 8, then push 0xB0 and pop on the same cycle. Required: count stays 8, no overflow, Salida=first stored word; 0xB0 emerges last after a full drain.
- Run 20 push/pop cycles at mixed rates so both pointers wrap at least twice. Required: output order matches input order, and almost_empty toggles at count=2 and 3.
- Fill to 5, pulse reset=0 asynchronously between clock edges. Required: count=0, empty=1, validSalida=0 and error flags 0 immediately, before the next edge; the next push/pop returns only the newly pushed data.
